// File: rtl/uart_rx_frame_counter.sv
// Edge/bit sequencer for the oversampling UART receiver: counts sample edges per bit and
// bits per frame, and decodes majority-vote strobes, bit type and end-of-bit/frame pulses.
module uart_rx_frame_counter #(
  parameter int DATA_WIDTH   = 8,
  parameter int PRESC_W      = 6,
  parameter int DEF_PRESCALE = 8,
  localparam int BIT_W       = $clog2(DATA_WIDTH + 4)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cnt_enable,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               par_en,
  input  logic               stop2,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic [1:0]         bit_type,
  output logic               sample_stb,
  output logic [1:0]         sample_idx,
  output logic               bit_end,
  output logic               frame_done
);

  localparam logic [PRESC_W-1:0] P_MIN     = PRESC_W'(4);
  localparam logic [BIT_W-1:0]   LAST_DATA = BIT_W'(DATA_WIDTH);
  localparam logic [BIT_W-1:0]   PAR_BIT   = BIT_W'(DATA_WIDTH + 1);

  logic [PRESC_W-1:0] p_q, p_clamped, p_last, mid;
  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d, n_last;
  logic               par_q, stop2_q;
  logic               edge_last, bit_last;

  assign p_clamped = (prescale < P_MIN) ? P_MIN : prescale;
  assign p_last    = p_q - PRESC_W'(1);
  assign mid       = p_q >> 1;
  assign n_last    = PAR_BIT + BIT_W'(par_q) + BIT_W'(stop2_q);
  assign edge_last = (edge_cnt_q == p_last);
  assign bit_last  = (bit_cnt_q == n_last);

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!cnt_enable) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (edge_last) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_last ? '0 : bit_cnt_q + BIT_W'(1);
    end else begin
      edge_cnt_d = edge_cnt_q + PRESC_W'(1);
    end
  end

  // Configuration only tracks the inputs while idle, so a frame never sees it change.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      p_q        <= PRESC_W'(DEF_PRESCALE);
      par_q      <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      if (!cnt_enable) begin
        p_q     <= p_clamped;
        par_q   <= par_en;
        stop2_q <= stop2;
      end
    end
  end

  always_comb begin
    sample_stb = 1'b0;
    sample_idx = 2'd0;
    if (cnt_enable) begin
      if (edge_cnt_q == mid - PRESC_W'(1)) begin
        sample_stb = 1'b1;
        sample_idx = 2'd0;
      end else if (edge_cnt_q == mid) begin
        sample_stb = 1'b1;
        sample_idx = 2'd1;
      end else if (edge_cnt_q == mid + PRESC_W'(1)) begin
        sample_stb = 1'b1;
        sample_idx = 2'd2;
      end
    end
  end

  always_comb begin
    if (bit_cnt_q == '0)                  bit_type = 2'd0;
    else if (bit_cnt_q <= LAST_DATA)      bit_type = 2'd1;
    else if (par_q && bit_cnt_q == PAR_BIT) bit_type = 2'd2;
    else                                  bit_type = 2'd3;
  end

  assign bit_end    = cnt_enable && edge_last;
  assign frame_done = bit_end && bit_last;
  assign edge_cnt   = edge_cnt_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_counter.sv
// Scoreboard bench for uart_rx_frame_counter: stimulus queues the expected strobe/pulse
// events of each frame, a negedge monitor pops one per event the DUT presents.
module tb_uart_rx_frame_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cnt_enable = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       stop2 = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic [1:0] bit_type;
  logic       sample_stb;
  logic [1:0] sample_idx;
  logic       bit_end;
  logic       frame_done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [5:0] e;
    logic [3:0] b;
    logic [1:0] t;
    logic       stb;
    logic [1:0] idx;
    logic       be;
    logic       fd;
  } ev_t;

  ev_t exp_q[$];

  uart_rx_frame_counter dut (
    .CLK        (CLK),
    .RST        (RST),
    .cnt_enable (cnt_enable),
    .prescale   (prescale),
    .par_en     (par_en),
    .stop2      (stop2),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .bit_type   (bit_type),
    .sample_stb (sample_stb),
    .sample_idx (sample_idx),
    .bit_end    (bit_end),
    .frame_done (frame_done)
  );

  always #5 CLK = ~CLK;

  // Bit 0 start, 1..8 data, 9 parity when enabled, everything after is stop.
  function automatic logic [1:0] type_of(int b, bit par);
    if (b == 0) return 2'd0;
    if (b <= 8) return 2'd1;
    if (b == 9 && par) return 2'd2;
    return 2'd3;
  endfunction

  task automatic push_bit(int p, int b, int n, bit par, int last_e);
    ev_t ev;
    int  mid;
    bit  stb, be;
    mid = p / 2;
    for (int e = 0; e <= last_e; e++) begin
      stb = (e >= mid - 1) && (e <= mid + 1);
      be  = (e == p - 1);
      if (stb || be) begin
        ev.e   = 6'(e);
        ev.b   = 4'(b);
        ev.t   = type_of(b, par);
        ev.stb = stb;
        ev.idx = stb ? 2'(e - mid + 1) : 2'd0;
        ev.be  = be;
        ev.fd  = be && (b == n - 1);
        exp_q.push_back(ev);
      end
    end
  endtask

  task automatic push_frames(int p, int n, bit par, int frames);
    for (int f = 0; f < frames; f++)
      for (int b = 0; b < n; b++)
        push_bit(p, b, n, par, p - 1);
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  always @(negedge CLK) begin
    ev_t got, want;
    if (sample_stb || bit_end || frame_done) begin
      got = '{e: edge_cnt, b: bit_cnt, t: bit_type, stb: sample_stb,
              idx: sample_idx, be: bit_end, fd: frame_done};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event: got e=%0d b=%0d t=%0d stb=%0d idx=%0d be=%0d fd=%0d, want none",
                 got.e, got.b, got.t, got.stb, got.idx, got.be, got.fd);
      end else begin
        want = exp_q.pop_front();
        if (got != want) begin
          miscompares++;
          $display("FAIL event: got e=%0d b=%0d t=%0d stb=%0d idx=%0d be=%0d fd=%0d, want e=%0d b=%0d t=%0d stb=%0d idx=%0d be=%0d fd=%0d",
                   got.e, got.b, got.t, got.stb, got.idx, got.be, got.fd,
                   want.e, want.b, want.t, want.stb, want.idx, want.be, want.fd);
        end
      end
    end
  end

  task automatic run_cfg(logic [5:0] pre, bit par, bit s2);
    prescale = pre;
    par_en   = par;
    stop2    = s2;
    tick(2);
  endtask

  initial begin
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_edge_cnt", edge_cnt, 0);
    chk("reset_bit_cnt", bit_cnt, 0);
    chk("reset_pulses", {sample_stb, bit_end, frame_done}, 0);
    tick(1);
    RST = 1'b0;

    // 8x, 8N1: one 10-bit frame.
    run_cfg(6'd8, 1'b0, 1'b0);
    push_frames(8, 10, 1'b0, 1);
    cnt_enable = 1'b1;
    tick(80);
    cnt_enable = 1'b0;
    tick(1);
    chk("idle_edge_cnt", edge_cnt, 0);
    chk("idle_bit_cnt", bit_cnt, 0);

    // 8x, parity + 2 stop: two back-to-back 12-bit frames.
    run_cfg(6'd8, 1'b1, 1'b1);
    push_frames(8, 12, 1'b1, 2);
    cnt_enable = 1'b1;
    tick(192);
    cnt_enable = 1'b0;

    run_cfg(6'd16, 1'b0, 1'b0);
    push_frames(16, 10, 1'b0, 1);
    cnt_enable = 1'b1;
    tick(160);
    cnt_enable = 1'b0;

    run_cfg(6'd5, 1'b0, 1'b0);
    push_frames(5, 10, 1'b0, 1);
    cnt_enable = 1'b1;
    tick(50);
    cnt_enable = 1'b0;

    // prescale 2 behaves as 4
    run_cfg(6'd2, 1'b0, 1'b0);
    push_frames(4, 10, 1'b0, 1);
    cnt_enable = 1'b1;
    tick(40);
    cnt_enable = 1'b0;

    // Prescale change while enabled is ignored until the next idle cycle.
    run_cfg(6'd8, 1'b0, 1'b0);
    for (int b = 0; b < 5; b++) push_bit(8, b, 10, 1'b0, 7);
    cnt_enable = 1'b1;
    tick(20);
    prescale = 6'd16;
    tick(20);
    cnt_enable = 1'b0;
    tick(1);
    for (int b = 0; b < 2; b++) push_bit(16, b, 10, 1'b0, 15);
    cnt_enable = 1'b1;
    tick(32);
    cnt_enable = 1'b0;

    // Drop enable while showing bit 4 edge 5 (a strobe edge): outputs gated, then cleared.
    run_cfg(6'd8, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++) push_bit(8, b, 10, 1'b0, 7);
    push_bit(8, 4, 10, 1'b0, 4);
    cnt_enable = 1'b1;
    tick(37);
    cnt_enable = 1'b0;
    @(negedge CLK);
    chk("drop_edge_cnt", edge_cnt, 5);
    chk("drop_bit_cnt", bit_cnt, 4);
    chk("drop_gated", {sample_stb, sample_idx, bit_end, frame_done}, 0);
    @(negedge CLK);
    chk("drop_clear_edge", edge_cnt, 0);
    chk("drop_clear_bit", bit_cnt, 0);
    tick(1);

    // Async reset at bit 6; enable held so counting resumes with reset config (8x, 8N1).
    run_cfg(6'd16, 1'b1, 1'b1);
    for (int b = 0; b < 6; b++) push_bit(16, b, 12, 1'b1, 15);
    push_bit(16, 6, 12, 1'b1, 2);
    cnt_enable = 1'b1;
    tick(99);
    chk("pre_rst_bit_cnt", bit_cnt, 6);
    RST = 1'b1;
    #1;
    chk("rst_edge_cnt", edge_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_bit_type", bit_type, 0);
    chk("rst_pulses", {sample_stb, bit_end, frame_done}, 0);
    tick(2);
    RST = 1'b0;
    push_frames(8, 10, 1'b0, 1);
    tick(80);
    cnt_enable = 1'b0;
    tick(3);

    chk("pending_events", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
